// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, FSM encoding,
// control bundle and operand-usage decode.
package hazard_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic if_stall;
        logic id_stall;
        logic ex_stall;
        logic me_stall;
        logic id_flush;
        logic ex_flush;
        logic wb_bubble;
        logic pc_redirect;
    } hz_ctrl_t;

    // Upper-immediate and JAL forms carry no rs1 operand.
    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with enable and synchronous active-high reset.
module hazard_sat_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, EX redirect
// flushes and single-cycle load-use interlock, plus stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       ID_opcode,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [6:0]       EX_opcode,
    input  logic [4:0]       EX_rd,
    input  logic             EX_redirect,
    input  logic             ME_mem_req,
    input  logic             ME_mem_ready,
    output logic             IF_stall,
    output logic             ID_stall,
    output logic             EX_stall,
    output logic             ME_stall,
    output logic             ID_flush,
    output logic             EX_flush,
    output logic             WB_bubble,
    output logic             pc_redirect,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    // The RUN cycle that enters MEM_WAIT is itself a wait cycle, so the counter
    // trips one value early to give MEM_TIMEOUT wait cycles in total.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);

    hz_state_e         state_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              load_use;
    hz_ctrl_t          ctrl;

    assign mem_wait = ME_mem_req && !ME_mem_ready;

    assign load_use = (EX_opcode == OPC_LOAD) && (EX_rd != 5'd0) &&
                      ((uses_rs1(ID_opcode) && (ID_rs1 == EX_rd)) ||
                       (uses_rs2(ID_opcode) && (ID_rs2 == EX_rd)));

    // Priority: reset > error > memory wait > redirect > load-use > normal.
    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl = '0;
        end else if ((state_q == ST_ERROR) || mem_wait) begin
            ctrl.if_stall  = 1'b1;
            ctrl.id_stall  = 1'b1;
            ctrl.ex_stall  = 1'b1;
            ctrl.me_stall  = 1'b1;
            ctrl.wb_bubble = 1'b1;
        end else if (EX_redirect) begin
            ctrl.pc_redirect = 1'b1;
            ctrl.id_flush    = 1'b1;
            ctrl.ex_flush    = 1'b1;
        end else if (load_use) begin
            ctrl.if_stall = 1'b1;
            ctrl.id_stall = 1'b1;
            ctrl.ex_flush = 1'b1;
        end
    end

    assign IF_stall    = ctrl.if_stall;
    assign ID_stall    = ctrl.id_stall;
    assign EX_stall    = ctrl.ex_stall;
    assign ME_stall    = ctrl.me_stall;
    assign ID_flush    = ctrl.id_flush;
    assign EX_flush    = ctrl.ex_flush;
    assign WB_bubble   = ctrl.wb_bubble;
    assign pc_redirect = ctrl.pc_redirect;
    assign state       = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_wait) begin
                        state_q  <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_wait) begin
                        state_q  <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_q     <= ST_ERROR;
                        wait_cnt    <= '0;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
                default: begin
                    state_q  <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    hazard_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl.if_stall),
        .count (stall_cycles)
    );

    hazard_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl.pc_redirect),
        .count (flush_events)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int unsigned MT   = 8;
    localparam int unsigned CW   = 6;
    localparam int unsigned VW   = 11 + 2 * CW;
    localparam int          MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    ID_opcode;
    logic [4:0]    ID_rs1, ID_rs2;
    logic [6:0]    EX_opcode;
    logic [4:0]    EX_rd;
    logic          EX_redirect, ME_mem_req, ME_mem_ready;
    logic          IF_stall, ID_stall, EX_stall, ME_stall;
    logic          ID_flush, EX_flush, WB_bubble, pc_redirect;
    logic [1:0]    state;
    logic          mem_timeout;
    logic [CW-1:0] stall_cycles, flush_events;

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_opcode    (ID_opcode),
        .ID_rs1       (ID_rs1),
        .ID_rs2       (ID_rs2),
        .EX_opcode    (EX_opcode),
        .EX_rd        (EX_rd),
        .EX_redirect  (EX_redirect),
        .ME_mem_req   (ME_mem_req),
        .ME_mem_ready (ME_mem_ready),
        .IF_stall     (IF_stall),
        .ID_stall     (ID_stall),
        .EX_stall     (EX_stall),
        .ME_stall     (ME_stall),
        .ID_flush     (ID_flush),
        .EX_flush     (EX_flush),
        .WB_bubble    (WB_bubble),
        .pc_redirect  (pc_redirect),
        .state        (state),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] exp_q[$];
    string         name_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    // Model state: error latched, consecutive wait cycles, previous cycle waited.
    int m_err = 0, m_run = 0, m_prev_wait = 0, m_stall = 0, m_flush = 0;

    localparam logic [6:0] NOP_OP = 7'b0010011;
    logic [6:0] opc_tbl [9] = '{OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_LUI,
                                OPC_AUIPC, OPC_JAL, OPC_JALR, NOP_OP};

    // Monitor: every cycle the DUT presents a full control word.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [VW-1:0] act, exv;
            string nm;
            exv = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {IF_stall, ID_stall, EX_stall, ME_stall, ID_flush, EX_flush,
                   WB_bubble, pc_redirect, state, mem_timeout, stall_cycles, flush_events};
            n_cmp++;
            if (act !== exv) begin
                n_bad++;
                $display("FAIL %s t=%0t: got %b expected %b", nm, $time, act, exv);
            end
        end
    end

    task automatic step(input string nm, input logic r,
                        input logic [6:0] idop, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [6:0] exop, input logic [4:0] rd,
                        input logic redir, input logic req, input logic rdy);
        bit w, lu, r1, r2;
        bit [7:0] c;
        int st;
        rst = r; ID_opcode = idop; ID_rs1 = rs1; ID_rs2 = rs2;
        EX_opcode = exop; EX_rd = rd; EX_redirect = redir;
        ME_mem_req = req; ME_mem_ready = rdy;
        w  = req && !rdy;
        r1 = !(idop inside {7'b0110111, 7'b0010111, 7'b1101111});
        r2 = idop inside {7'b0110011, 7'b0100011, 7'b1100011};
        lu = (exop == 7'b0000011) && (rd != 0) && ((r1 && rs1 == rd) || (r2 && rs2 == rd));
        c  = 8'h00;   // {ifs, ids, exs, mes, idf, exf, wbb, pcr}
        if (!r) begin
            if (m_err != 0 || w) c = 8'b1111_0010;
            else if (redir)      c = 8'b0000_1101;
            else if (lu)         c = 8'b1100_0100;
        end
        st = (m_err != 0) ? 2 : ((m_prev_wait != 0) ? 1 : 0);
        exp_q.push_back({c, 2'(st), 1'(m_err), CW'(m_stall), CW'(m_flush)});
        name_q.push_back(nm);
        @(posedge clk);
        if (r) begin
            m_err = 0; m_run = 0; m_prev_wait = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (c[7] && m_stall < MAXC) m_stall++;
            if (c[0] && m_flush < MAXC) m_flush++;
            if (m_err == 0) begin
                if (w) begin
                    m_run++;
                    m_prev_wait = 1;
                    if (m_run >= int'(MT)) m_err = 1;
                end else begin
                    m_run = 0;
                    m_prev_wait = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input string nm, input logic r);
        step(nm, r, NOP_OP, 5'd0, 5'd0, NOP_OP, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; ID_opcode = NOP_OP; ID_rs1 = '0; ID_rs2 = '0;
        EX_opcode = NOP_OP; EX_rd = '0; EX_redirect = 1'b0;
        ME_mem_req = 1'b0; ME_mem_ready = 1'b1;
        @(posedge clk); #1;

        idle("reset", 1'b1);
        idle("post_reset", 1'b0);

        step("load_use_x5", 1'b0, OPC_OP, 5'd5, 5'd7, OPC_LOAD, 5'd5, 1'b0, 1'b0, 1'b1);
        step("load_use_next", 1'b0, OPC_OP, 5'd5, 5'd7, NOP_OP, 5'd0, 1'b0, 1'b0, 1'b1);
        step("load_x0", 1'b0, OPC_OP, 5'd0, 5'd0, OPC_LOAD, 5'd0, 1'b0, 1'b0, 1'b1);
        step("lui_no_rs", 1'b0, OPC_LUI, 5'd5, 5'd5, OPC_LOAD, 5'd5, 1'b0, 1'b0, 1'b1);
        step("store_rs2", 1'b0, OPC_STORE, 5'd1, 5'd9, OPC_LOAD, 5'd9, 1'b0, 1'b0, 1'b1);
        step("addi_rs2", 1'b0, NOP_OP, 5'd1, 5'd9, OPC_LOAD, 5'd9, 1'b0, 1'b0, 1'b1);

        idle("reset2", 1'b1);
        for (int i = 0; i < 3; i++)
            step("mem_wait3", 1'b0, NOP_OP, 5'd0, 5'd0, OPC_LOAD, 5'd3, 1'b0, 1'b1, 1'b0);
        step("mem_done", 1'b0, NOP_OP, 5'd0, 5'd0, OPC_LOAD, 5'd3, 1'b0, 1'b1, 1'b1);
        idle("after_wait", 1'b0);

        for (int i = 0; i < 2; i++)
            step("redir_wait", 1'b0, NOP_OP, 5'd0, 5'd0, OPC_BRANCH, 5'd0, 1'b1, 1'b1, 1'b0);
        step("redir_taken", 1'b0, NOP_OP, 5'd0, 5'd0, OPC_BRANCH, 5'd0, 1'b1, 1'b1, 1'b1);
        idle("after_redir", 1'b0);

        step("lu_and_redir", 1'b0, OPC_OP, 5'd4, 5'd4, OPC_LOAD, 5'd4, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 2; i++)
            step("wait_then_rst", 1'b0, NOP_OP, 5'd0, 5'd0, NOP_OP, 5'd0, 1'b0, 1'b1, 1'b0);
        step("rst_in_wait", 1'b1, NOP_OP, 5'd0, 5'd0, NOP_OP, 5'd0, 1'b0, 1'b1, 1'b0);
        idle("after_rst_wait", 1'b0);

        for (int i = 0; i < int'(MT); i++)
            step("timeout_run", 1'b0, NOP_OP, 5'd0, 5'd0, OPC_LOAD, 5'd1, 1'b0, 1'b1, 1'b0);
        step("error_ready", 1'b0, OPC_OP, 5'd2, 5'd2, OPC_LOAD, 5'd2, 1'b1, 1'b1, 1'b1);
        idle("error_hold", 1'b0);
        step("rst_in_error", 1'b1, NOP_OP, 5'd0, 5'd0, NOP_OP, 5'd0, 1'b1, 1'b1, 1'b0);
        idle("after_error", 1'b0);

        for (int i = 0; i < MAXC + 5; i++)
            step("stall_sat", 1'b0, OPC_BRANCH, 5'd1, 5'd6, OPC_LOAD, 5'd6, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < MAXC + 5; i++)
            step("flush_sat", 1'b0, NOP_OP, 5'd0, 5'd0, OPC_JAL, 5'd1, 1'b1, 1'b0, 1'b1);
        idle("reset3", 1'b1);

        for (int i = 0; i < 600; i++) begin
            step("random", ($urandom_range(0, 99) < 2),
                 opc_tbl[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 opc_tbl[$urandom_range(0, 8)], 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 55));
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 64: consecutive ME wait cycles before a memory timeout error.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ID_opcode  input  7  opcode of the instruction in ID.
REQ-006 ID_rs1, ID_rs2  input  5 each  source register indices in ID.
REQ-007 EX_opcode  input  7  opcode of the instruction in EX.
REQ-008 EX_rd  input  5  destination register index in EX.
REQ-009 EX_redirect  input  1  branch taken, JAL or JALR resolved in EX.
REQ-010 ME_mem_req  input  1  load/store active in ME.
REQ-011 ME_mem_ready  input  1  data memory completes the ME access this cycle.
REQ-012 IF_stall, ID_stall, EX_stall, ME_stall  output  1 each  hold the named stage register.
REQ-013 ID_flush  output  1  load NOP into the IF/ID register.
REQ-014 EX_flush  output  1  load NOP into the ID/EX register.
REQ-015 WB_bubble  output  1  load NOP into the ME/WB register.
REQ-016 pc_redirect  output  1  PC takes the EX target this cycle.
REQ-017 state  output  2  current FSM state: RUN=0, MEM_WAIT=1, ERROR=2.
REQ-018 mem_timeout  output  1  sticky error flag.
REQ-019 stall_cycles, flush_events  output  CNT_W each  performance counters.

Function
REQ-020 FSM states RUN, MEM_WAIT and ERROR; outputs are combinational from state plus current inputs.
REQ-021 mem_wait = ME_mem_req && !ME_mem_ready.
REQ-022 While mem_wait holds in RUN or MEM_WAIT: IF/ID/EX/ME_stall=1, WB_bubble=1, no flush, pc_redirect=0.
REQ-023 RUN->MEM_WAIT when mem_wait; MEM_WAIT->RUN on the cycle ME_mem_ready=1, and that cycle behaves as RUN.
REQ-024 The wait counter increments each cycle in MEM_WAIT and clears on leaving MEM_WAIT.
REQ-025 The wait counter reaching MEM_TIMEOUT-1 while mem_wait still holds moves the FSM to ERROR and sets mem_timeout.
REQ-026 ERROR holds all four stalls and WB_bubble at 1 until rst; it ignores all inputs.
REQ-027 Redirect (RUN, no mem_wait, EX_redirect=1): pc_redirect=1, ID_flush=1, EX_flush=1, no stalls.
REQ-028 uses_rs1 = ID_opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
REQ-029 uses_rs2 = ID_opcode in {0110011, 0100011, 1100011}.
REQ-030 Load-use = EX_opcode==0000011 && EX_rd!=0 && ((uses_rs1 && ID_rs1==EX_rd) || (uses_rs2 && ID_rs2==EX_rd)).
REQ-031 On load-use (RUN, no mem_wait, no redirect): IF_stall=1, ID_stall=1, EX_flush=1, all else 0.
REQ-032 A load-use stall lasts exactly one cycle; the next cycle the load is in ME and the consumer later takes the WB-forwarded value.
REQ-033 Priority: ERROR > mem_wait > redirect > load-use > normal (all outputs 0).
REQ-034 A redirect arriving during mem_wait is not lost: EX stays frozen and the redirect is taken on the first non-wait cycle.
REQ-035 stall_cycles increments on every cycle with IF_stall=1 and saturates at all-ones.
REQ-036 flush_events increments on every cycle with pc_redirect=1 and saturates at all-ones.

Reset
REQ-037 On rst=1 at a clock edge: state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0, flush_events=0.
REQ-038 While rst=1, all stall, flush and bubble outputs and pc_redirect are 0, including a reset asserted mid-MEM_WAIT or in ERROR.

Structure
REQ-039 A shared package holds the opcode constants (LOAD, STORE, BRANCH, OP, LUI, AUIPC, JAL, JALR) and the state encoding; forwarding and decode logic use the same package.
REQ-040 One sub-module, hazard_sat_cnt (parameterised CNT_W, enable-increment, saturating, sync reset), is instantiated twice.

Verification
REQ-041 Load x5 in EX with ADD x6,x5,x7 in ID -> exactly one cycle of IF_stall=ID_stall=EX_flush=1; stall_cycles goes 0->1.
REQ-042 Load x0 in EX with ADD x6,x0,x0 in ID; and LUI x6 in ID with EX_rd=5 -> no stall in either case.
REQ-043 ME_mem_ready low for 3 cycles -> all stalls and WB_bubble high for 3 cycles, state=1, then RUN; stall_cycles=3.
REQ-044 EX_redirect=1 while ME_mem_ready low for 2 cycles -> pc_redirect=1 only on the 3rd cycle; flush_events=1.
REQ-045 ME_mem_ready held low for MEM_TIMEOUT cycles -> state=2 and mem_timeout=1, held; rst clears to RUN.
REQ-046 Load-use together with EX_redirect -> redirect only (ID_flush=EX_flush=1, IF_stall=0).
